wb_timer: RTL and testbench
===========================

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 'h3000_0000, byte address of the register window (16-byte aligned).
REQ-002 SHALL have parameter PRESCALE_RESET, default 0, reset value of the prescaler register.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have Wishbone classic responder inputs: stb_i 1, cyc_i 1, we_i 1, adr_i 32, sel_i 4, dat_i 32.
REQ-006 SHALL have Wishbone responder outputs: ack_o 1, err_o 1, rty_o 1 (tied 0), dat_o 32.
REQ-007 SHALL have port timer_irq_o  output  1  machine timer interrupt request, level.

Function
REQ-008 Register map (offset from BASE_ADDRESS): 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 MTIMECMP_LO, 0xC MTIMECMP_HI, 0x10 PRESCALE (bits 15:0 used; 31:16 read 0, ignored on write).
REQ-009 Decode: selected = stb_i & cyc_i & adr_i in [BASE_ADDRESS, BASE_ADDRESS+0x14); outside that window the block SHALL drive no ack/err.
REQ-010 Responder FSM states IDLE, RESP: IDLE->RESP on selected; RESP->IDLE unconditionally after one cycle.
REQ-011 In RESP, exactly one of ack_o/err_o SHALL be high for exactly one cycle; both low in IDLE.
REQ-012 err_o SHALL be asserted instead of ack_o when adr_i[1:0] != 0 or sel_i == 0; register state SHALL be unchanged on err.
REQ-013 Writes SHALL take effect on the clock edge entering RESP, honouring sel_i per byte lane.
REQ-014 Read data SHALL be captured on the edge entering RESP and held on dat_o during RESP; dat_o SHALL be 0 in IDLE.
REQ-015 Prescaler counter SHALL count 0..PRESCALE; mtime (64-bit) increments by 1 when counter equals PRESCALE, counter then returns to 0; PRESCALE=0 increments every cycle.
REQ-016 mtime SHALL wrap from 'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-017 A bus write to MTIME_LO/HI SHALL override the increment in the same cycle (written value loaded, no +1).
REQ-018 A write to PRESCALE SHALL also clear the prescaler counter.
REQ-019 timer_irq_o SHALL be registered: high the cycle after unsigned mtime >= mtimecmp holds, low the cycle after it fails.
REQ-020 A stb_i held high through RESP SHALL start a new transaction in the following IDLE cycle (back-to-back yields ack every other cycle).
REQ-021 Deassertion of cyc_i during RESP SHALL NOT cancel the pending ack/err pulse.

Reset
REQ-022 On rst_ni low, asynchronously: FSM IDLE, ack_o=0, err_o=0, dat_o=0, mtime=0, prescaler counter=0, PRESCALE=PRESCALE_RESET, mtimecmp='hFFFF_FFFF_FFFF_FFFF, timer_irq_o=0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no ack/err and no register write.
REQ-024 First transaction SHALL be accepted in the first cycle after rst_ni rises.

Structure
REQ-025 Register offsets and FSM state encodings SHALL live in the shared params package alongside existing opcode/funct3 constants.
REQ-026 Single module; no sub-module required (64-bit counter inline).
REQ-027 Implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-028 Reset then read MTIME_LO after 10 cycles, PRESCALE=0 -> ack one cycle after stb, dat_o within 10..13.
REQ-029 Write MTIMECMP_HI=0, MTIMECMP_LO=20, PRESCALE=0 -> timer_irq_o rises the cycle after mtime reaches 20, stays high.
REQ-030 Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=32'hFFFF_FFFF -> after wrap read MTIME_HI=0, MTIME_LO small; timer_irq_o falls.
REQ-031 Write PRESCALE=3 -> mtime advances once per 4 cycles (measured over 40 cycles: +10).
REQ-032 Write 32'hAABB_CCDD to MTIMECMP_LO with sel_i=4'b0010 -> read returns 32'hFFFF_CCFF.
REQ-033 Access offset 0x2 -> err_o one cycle, ack_o 0; access BASE_ADDRESS+0x20 -> neither ack_o nor err_o for 5 cycles.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared parameters for the core: RV opcode/funct3 constants plus
// the machine-timer register map and responder FSM encoding.
package wb_timer_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_PRESCALE    = 5'h10;
    localparam logic [31:0] WIN_SIZE       = 32'h14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle; signal names are from the responder side.
interface wb_timer_if;
    logic        stb_i;
    logic        cyc_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic [31:0] dat_o;

    modport slave (
        input  stb_i, cyc_i, we_i, adr_i, sel_i, dat_i,
        output ack_o, err_o, rty_o, dat_o
    );

    modport master (
        output stb_i, cyc_i, we_i, adr_i, sel_i, dat_i,
        input  ack_o, err_o, rty_o, dat_o
    );
endinterface

// File: rtl/wb_timer.sv
// RISC-V machine timer (mtime/mtimecmp) with prescaler, on a
// Wishbone classic responder port with single-cycle ack/err.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wb_timer_if.slave  wb,
    output logic       timer_irq_o
);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        irq_q;

    logic [31:0] off;
    logic        hit, bad, wr_en, tick;
    logic [31:0] rd_data;

    assign off = wb.adr_i - BASE_ADDRESS;
    // Unsigned wrap makes addresses below BASE land far outside the window.
    assign hit = wb.stb_i & wb.cyc_i & (off < WIN_SIZE);
    assign bad = (wb.adr_i[1:0] != 2'b00) | (wb.sel_i == 4'b0000);

    always_comb begin
        rd_data = 32'h0;
        unique case (off[4:0])
            OFF_MTIME_LO:    rd_data = mtime_q[31:0];
            OFF_MTIME_HI:    rd_data = mtime_q[63:32];
            OFF_MTIMECMP_LO: rd_data = cmp_q[31:0];
            OFF_MTIMECMP_HI: rd_data = cmp_q[63:32];
            OFF_PRESCALE:    rd_data = {16'h0, presc_q};
            default:         rd_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = 32'h0;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_RESP;
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        wr_en = wb.we_i;
                        dat_d = wb.we_i ? 32'h0 : rd_data;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick    = (cnt_q == presc_q);
        cnt_d   = tick ? 16'h0 : cnt_q + 16'h1;
        mtime_d = tick ? mtime_q + 64'h1 : mtime_q;
        cmp_d   = cmp_q;
        presc_d = presc_q;
        if (wr_en) begin
            unique case (off[4:0])
                OFF_MTIME_LO:
                    mtime_d = {mtime_q[63:32],
                        merge_bytes(mtime_q[31:0], wb.dat_i, wb.sel_i)};
                OFF_MTIME_HI:
                    mtime_d = {merge_bytes(mtime_q[63:32], wb.dat_i, wb.sel_i),
                        mtime_q[31:0]};
                OFF_MTIMECMP_LO:
                    cmp_d[31:0] = merge_bytes(cmp_q[31:0], wb.dat_i, wb.sel_i);
                OFF_MTIMECMP_HI:
                    cmp_d[63:32] = merge_bytes(cmp_q[63:32], wb.dat_i, wb.sel_i);
                OFF_PRESCALE: begin
                    presc_d = {wb.sel_i[1] ? wb.dat_i[15:8] : presc_q[15:8],
                               wb.sel_i[0] ? wb.dat_i[7:0]  : presc_q[7:0]};
                    cnt_d   = 16'h0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
            mtime_q <= 64'h0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q <= PRESCALE_RESET;
            cnt_q   <= 16'h0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            irq_q   <= (mtime_q >= cmp_q);
        end
    end

    assign wb.ack_o    = ack_q;
    assign wb.err_o    = err_q;
    assign wb.rty_o    = 1'b0;
    assign wb.dat_o    = dat_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: vector table for register access,
// hand sequences for counting, irq, wrap, prescale and reset timing.
module tb_wb_timer;
    import wb_timer_pkg::*;

    localparam logic [31:0] B = 32'h3000_0000;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        eack;
        logic        eerr;
        logic        chk;
        logic [31:0] edat;
        string       name;
    } vec_t;

    logic clk;
    logic rst_ni;
    logic irq;
    int   pass_cnt;
    int   total_cnt;

    wb_timer_if bus ();

    wb_timer #(
        .BASE_ADDRESS  (B),
        .PRESCALE_RESET(16'h0)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .wb         (bus.slave),
        .timer_irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    task automatic chk_rng(input string n, input logic [31:0] got,
                           input logic [31:0] lo, input logic [31:0] hi);
        total_cnt++;
        if (got >= lo && got <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d..%0d", n, got, lo, hi);
    endtask

    task automatic drive(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.sel_i = sel;
        bus.dat_i = dat;
    endtask

    task automatic idle_bus();
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = 32'h0;
        bus.sel_i = 4'h0;
        bus.dat_i = 32'h0;
    endtask

    // Two edges per transfer: one entering RESP, one back to IDLE.
    task automatic xfer(input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output logic ack, output logic err,
                        output logic [31:0] rd);
        drive(we, adr, sel, dat);
        @(posedge clk); #1;
        ack = bus.ack_o;
        err = bus.err_o;
        rd  = bus.dat_o;
        idle_bus();
        @(posedge clk); #1;
    endtask

    vec_t        vecs[12];
    logic        a, e;
    logic [31:0] rd, rd2;
    int          n;
    logic        flag;
    logic [3:0]  pat;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        idle_bus();
        rst_ni = 1'b0;

        vecs[0]  = '{1'b1, B + 32'h08, 4'b0010, 32'hAABB_CCDD, 1, 0, 0, 32'h0, "cmplo_wr_lane1"};
        vecs[1]  = '{1'b0, B + 32'h08, 4'b1111, 32'h0, 1, 0, 1, 32'hFFFF_CCFF, "cmplo_rd_lane1"};
        vecs[2]  = '{1'b1, B + 32'h10, 4'b1111, 32'h1234_5678, 1, 0, 0, 32'h0, "ps_wr"};
        vecs[3]  = '{1'b0, B + 32'h10, 4'b1111, 32'h0, 1, 0, 1, 32'h0000_5678, "ps_rd_upper0"};
        vecs[4]  = '{1'b1, B + 32'h10, 4'b1111, 32'h0, 1, 0, 0, 32'h0, "ps_wr0"};
        vecs[5]  = '{1'b0, B + 32'h10, 4'b1111, 32'h0, 1, 0, 1, 32'h0, "ps_rd0"};
        vecs[6]  = '{1'b0, B + 32'h02, 4'b1111, 32'h0, 0, 1, 1, 32'h0, "misalign_err"};
        vecs[7]  = '{1'b1, B + 32'h08, 4'b0000, 32'h0, 0, 1, 0, 32'h0, "sel0_err"};
        vecs[8]  = '{1'b0, B + 32'h08, 4'b1111, 32'h0, 1, 0, 1, 32'hFFFF_CCFF, "cmplo_after_err"};
        vecs[9]  = '{1'b1, B + 32'h0C, 4'b1100, 32'h1234_5678, 1, 0, 0, 32'h0, "cmphi_wr_hi"};
        vecs[10] = '{1'b0, B + 32'h0C, 4'b1111, 32'h0, 1, 0, 1, 32'h1234_FFFF, "cmphi_rd"};
        vecs[11] = '{1'b0, B + 32'h12, 4'b1111, 32'h0, 0, 1, 0, 32'h0, "misalign_ps_err"};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(bus.ack_o), 64'h0);
        chk("rst_err", 64'(bus.err_o), 64'h0);
        chk("rst_dat", 64'(bus.dat_o), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rty_tied", 64'(bus.rty_o), 64'h0);
        rst_ni = 1'b1;

        repeat (10) @(posedge clk);
        #1;
        xfer(1'b0, B + 32'h00, 4'hF, 32'h0, a, e, rd);
        chk("mtime10_ack", {62'h0, a, e}, 64'h2);
        chk_rng("mtime10_val", rd, 32'd10, 32'd13);

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, a, e, rd);
            chk({vecs[i].name, "_resp"}, {62'h0, a, e}, {62'h0, vecs[i].eack, vecs[i].eerr});
            if (vecs[i].chk) chk({vecs[i].name, "_dat"}, 64'(rd), 64'(vecs[i].edat));
        end

        xfer(1'b1, B + 32'h0C, 4'hF, 32'h0, a, e, rd);
        xfer(1'b1, B + 32'h08, 4'hF, 32'd20, a, e, rd);
        xfer(1'b1, B + 32'h00, 4'hF, 32'h0, a, e, rd);
        chk("irq_low_after_clear", 64'(irq), 64'h0);
        n = 0;
        while (!irq && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("irq_rise_cycles", 64'(n), 64'd20);
        flag = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            flag = flag & irq;
        end
        chk("irq_stays_high", 64'(flag), 64'h1);

        xfer(1'b1, B + 32'h04, 4'hF, 32'hFFFF_FFFF, a, e, rd);
        xfer(1'b1, B + 32'h00, 4'hF, 32'hFFFF_FFFF, a, e, rd);
        xfer(1'b0, B + 32'h04, 4'hF, 32'h0, a, e, rd);
        chk("wrap_hi", 64'(rd), 64'h0);
        xfer(1'b0, B + 32'h00, 4'hF, 32'h0, a, e, rd);
        chk_rng("wrap_lo", rd, 32'd0, 32'd8);
        chk("wrap_irq_fall", 64'(irq), 64'h0);

        xfer(1'b1, B + 32'h10, 4'hF, 32'd3, a, e, rd);
        xfer(1'b0, B + 32'h00, 4'hF, 32'h0, a, e, rd);
        repeat (38) @(posedge clk);
        #1;
        xfer(1'b0, B + 32'h00, 4'hF, 32'h0, a, e, rd2);
        chk("ps3_delta40", 64'(rd2 - rd), 64'd10);

        drive(1'b0, B + 32'h10, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pat[i] = bus.ack_o;
        end
        idle_bus();
        chk("b2b_ack_pattern", 64'(pat), 64'h5);
        @(posedge clk); #1;

        drive(1'b0, B + 32'h20, 4'hF, 32'h0);
        flag = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            flag = flag | bus.ack_o | bus.err_o;
        end
        idle_bus();
        chk("outside_no_resp", 64'(flag), 64'h0);

        drive(1'b1, B + 32'h08, 4'hF, 32'h0);
        #2 rst_ni = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_resp", {62'h0, bus.ack_o, bus.err_o}, 64'h0);
        idle_bus();
        #2 rst_ni = 1'b1;
        xfer(1'b0, B + 32'h08, 4'hF, 32'h0, a, e, rd);
        chk("first_after_rst_ack", {62'h0, a, e}, 64'h2);
        chk("midrst_no_write", 64'(rd), 64'hFFFF_FFFF);
        chk("irq_after_rst", 64'(irq), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
